// File: rtl/fire_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// fire_alarm_ctrl
//
// Smoke-level alarm controller. The smoke reading is compared with an "on" and
// an "off" threshold (hysteresis band in between). A reading has to persist for
// a number of consecutive cycles before the alarm is raised or dropped. In
// latching mode the alarm holds until it is acknowledged while no smoke is seen.
//
// Ports
//   clk             in   1      system clock, rising edge
//   rst_n           in   1      asynchronous active-low reset
//   smoke_detector  in   WIDTH  unsigned smoke level, sampled every cycle
//   ack_clear       in   1      request to clear a latched alarm (LATCH=1 only)
//   alarmEnable     out  1      registered alarm drive, 1 = sound alarm
//   smoke_present   out  1      registered flag: last sampled level >= THRESH_ON
// ---------------------------------------------------------------------------
module fire_alarm_ctrl #(
  parameter int WIDTH      = 8,
  parameter int THRESH_ON  = 4,
  parameter int THRESH_OFF = 2,
  parameter int ON_CYCLES  = 2,
  parameter int OFF_CYCLES = 4,
  parameter bit LATCH      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] smoke_detector,
  input  logic             ack_clear,
  output logic             alarmEnable,
  output logic             smoke_present
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [WIDTH-1:0] ON_LVL  = WIDTH'(THRESH_ON);
  localparam logic [WIDTH-1:0] OFF_LVL = WIDTH'(THRESH_OFF);
  localparam logic [CW-1:0]    ON_CNT  = CW'(ON_CYCLES);
  localparam logic [CW-1:0]    OFF_CNT = CW'(OFF_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    ALARM    = 2'd2,
    CLEARING = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            alarm_reg, alarm_next;
  logic            present_reg;

  logic            hi, lo;
  logic [CW-1:0]   cnt_inc;

  assign hi = (smoke_detector >= ON_LVL);
  assign lo = (smoke_detector <= OFF_LVL);

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_reg == {CW{1'b1}}) ? cnt_reg : (cnt_reg + CNT_ONE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (hi) begin
          if (ON_CYCLES == 1) begin
            state_next = ALARM;
            cnt_next   = '0;
          end else begin
            state_next = PENDING;
            cnt_next   = CNT_ONE;
          end
        end
      end

      PENDING: begin
        if (hi) begin
          if (cnt_inc >= ON_CNT) begin
            state_next = ALARM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          // Any non-hi level (including mid-band) aborts the pending raise.
          state_next = IDLE;
          cnt_next   = '0;
        end
      end

      ALARM: begin
        cnt_next = '0;
        if (LATCH) begin
          // Smoke clearing is ignored; only an acknowledge with no smoke clears.
          if (ack_clear && !hi) begin
            state_next = IDLE;
          end
        end else if (lo) begin
          if (OFF_CYCLES == 1) begin
            state_next = IDLE;
          end else begin
            state_next = CLEARING;
            cnt_next   = CNT_ONE;
          end
        end
      end

      CLEARING: begin
        if (lo) begin
          if (cnt_inc >= OFF_CNT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          // Mid-band or smoke returning: fall back to a full alarm.
          state_next = ALARM;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Registered drive decoded from the state being entered, so the output
    // flop always matches the state register.
    alarm_next = (state_next == ALARM) || (state_next == CLEARING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      alarm_reg   <= 1'b0;
      present_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      alarm_reg   <= alarm_next;
      present_reg <= hi;
    end
  end

  assign alarmEnable   = alarm_reg;
  assign smoke_present = present_reg;

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Directed testbench for fire_alarm_ctrl: a non-latching instance (defaults)
// and a latching instance share clock, reset and inputs.
module tb_fire_alarm_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] smoke;
  logic       ack;
  logic       alarm_nl, present_nl;
  logic       alarm_lt, present_lt;

  int checks = 0;
  int errors = 0;

  fire_alarm_ctrl #(.LATCH(1'b0)) dut_nl (
    .clk            (clk),
    .rst_n          (rst_n),
    .smoke_detector (smoke),
    .ack_clear      (ack),
    .alarmEnable    (alarm_nl),
    .smoke_present  (present_nl)
  );

  fire_alarm_ctrl #(.LATCH(1'b1)) dut_lt (
    .clk            (clk),
    .rst_n          (rst_n),
    .smoke_detector (smoke),
    .ack_clear      (ack),
    .alarmEnable    (alarm_lt),
    .smoke_present  (present_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %b @%0t", tag, got, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected alarm after each clock of the ramps (2 clocks per level).
  logic exp_up [16] = '{0,0, 0,0, 0,0, 0,0, 0,1, 1,1, 1,1, 1,1};
  logic exp_dn [16] = '{1,1, 1,1, 1,1, 1,1, 1,1, 1,1, 1,0, 0,0};

  initial begin
    rst_n = 1'b0;
    smoke = 8'd7;
    ack   = 1'b0;

    // 1: reset with smoke present, then release
    step(2);
    check("rst_alarm", alarm_nl, 1'b0);
    check("rst_present", present_nl, 1'b0);
    check("rst_alarm_lt", alarm_lt, 1'b0);
    rst_n = 1'b1;
    step(1);
    check("rel_present", present_nl, 1'b1);
    check("rel_alarm_c1", alarm_nl, 1'b0);
    step(1);
    check("rel_alarm_c2", alarm_nl, 1'b1);
    check("rel_alarm_lt_c2", alarm_lt, 1'b1);

    // Asynchronous reset mid-cycle, away from any rising edge
    #3;
    rst_n = 1'b0;
    #1;
    check("async_alarm", alarm_nl, 1'b0);
    check("async_present", present_nl, 1'b0);
    check("async_alarm_lt", alarm_lt, 1'b0);
    smoke = 8'd0;
    step(1);
    rst_n = 1'b1;
    step(1);

    // 2: ramp up 0..7
    for (int i = 0; i < 16; i++) begin
      smoke = 8'(i / 2);
      step(1);
      check($sformatf("up_lvl%0d_alarm", i / 2), alarm_nl, exp_up[i]);
      check($sformatf("up_lvl%0d_present", i / 2), present_nl, (i / 2) >= 4);
    end
    check("up_alarm_lt", alarm_lt, 1'b1);

    // 3: ramp down 7..0
    for (int i = 0; i < 16; i++) begin
      smoke = 8'(7 - i / 2);
      step(1);
      check($sformatf("dn_lvl%0d_alarm", 7 - i / 2), alarm_nl, exp_dn[i]);
    end
    check("dn_alarm_lt", alarm_lt, 1'b1);

    // 6: latched alarm holds through 20 clear cycles
    smoke = 8'd0;
    step(20);
    check("latch_hold", alarm_lt, 1'b1);
    ack   = 1'b1;
    smoke = 8'd6;
    step(1);
    check("latch_ack_hi_ignored", alarm_lt, 1'b1);
    smoke = 8'd0;
    step(1);
    check("latch_ack_clear", alarm_lt, 1'b0);
    check("nl_ack_no_effect", alarm_nl, 1'b0);
    ack = 1'b0;

    // 4: single-clock glitch never raises the alarm
    smoke = 8'd5;
    step(1);
    check("glitch_c1", alarm_nl, 1'b0);
    check("glitch_present", present_nl, 1'b1);
    smoke = 8'd0;
    step(1);
    check("glitch_c2", alarm_nl, 1'b0);
    step(3);
    check("glitch_after", alarm_nl, 1'b0);
    check("glitch_after_lt", alarm_lt, 1'b0);

    // 5: mid-band behaviour while in ALARM
    smoke = 8'd7;
    step(2);
    check("mid_raise", alarm_nl, 1'b1);
    smoke = 8'd3;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("mid_hold%0d", i), alarm_nl, 1'b1);
    end
    check("mid_present", present_nl, 1'b0);
    smoke = 8'd2; step(1); check("clr_abort_a", alarm_nl, 1'b1);
    smoke = 8'd1; step(1); check("clr_abort_b", alarm_nl, 1'b1);
    smoke = 8'd2; step(1); check("clr_abort_c", alarm_nl, 1'b1);
    smoke = 8'd3; step(1); check("clr_abort_d", alarm_nl, 1'b1);
    // Count restarted by the abort: three lo cycles keep it, the fourth drops it
    smoke = 8'd2;
    step(3);
    check("clr_restart_3", alarm_nl, 1'b1);
    step(1);
    check("clr_restart_4", alarm_nl, 1'b0);
    check("mid_alarm_lt", alarm_lt, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
